// File: rtl/axi_rd_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// axi_rd_pkg
// Shared definitions for the AXI read-channel arbiter and its picker.
// Contents:
//   state_e            : arbiter FSM states (IDLE, AR, R)
//   AXI_*_W            : fixed AXI field widths
//   ARLOCK_0 / ARCACHE_0 / ARPROT_0 : constant AR sideband values
// ---------------------------------------------------------------------------
package axi_rd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2
  } state_e;

  localparam int AXI_LEN_W   = 4;
  localparam int AXI_SIZE_W  = 3;
  localparam int AXI_BURST_W = 2;
  localparam int AXI_RESP_W  = 2;
  localparam int AXI_LOCK_W  = 2;
  localparam int AXI_CACHE_W = 4;
  localparam int AXI_PROT_W  = 3;

  localparam logic [AXI_LOCK_W-1:0]  ARLOCK_0  = '0;
  localparam logic [AXI_CACHE_W-1:0] ARCACHE_0 = '0;
  localparam logic [AXI_PROT_W-1:0]  ARPROT_0  = '0;

endpackage

// File: rtl/axi_rd_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker. Scans i_ptr, i_ptr+1, ...
// (wrapping at NUM_M-1 back to 0) and returns the first requester.
// Ports:
//   i_req     : request vector, bit 0 = master 0
//   i_ptr     : index with the highest priority this round
//   o_grant   : index of the chosen requester (0 when none)
//   o_any_req : at least one request is present
// ---------------------------------------------------------------------------
module rr_arbiter
  import axi_rd_pkg::*;
#(
  parameter int NUM_M = 4,
  parameter int PTR_W = (NUM_M > 1) ? $clog2(NUM_M) : 1
) (
  input  logic [NUM_M-1:0] i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [PTR_W-1:0] o_grant,
  output logic             o_any_req
);

  logic [PTR_W:0]   w_sum;
  logic [PTR_W-1:0] w_idx;

  // Walk the candidates in priority order; the first hit wins. The sum is
  // one bit wider so the modulo wrap can be done with a single subtract.
  always_comb begin
    o_grant   = '0;
    o_any_req = 1'b0;
    w_sum     = '0;
    w_idx     = '0;
    for (int i = 0; i < NUM_M; i++) begin
      w_sum = {1'b0, i_ptr} + (PTR_W+1)'(i);
      if (w_sum >= (PTR_W+1)'(NUM_M)) begin
        w_sum = w_sum - (PTR_W+1)'(NUM_M);
      end
      w_idx = w_sum[PTR_W-1:0];
      if (!o_any_req && i_req[w_idx]) begin
        o_any_req = 1'b1;
        o_grant   = w_idx;
      end
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// ---------------------------------------------------------------------------
// axi_rd_arbiter
// Shares one AXI read channel among NUM_M masters with round-robin priority.
// One burst is outstanding at a time: a master is granted in IDLE, its AR is
// forwarded in AR, and R beats are steered back to it in R until RLAST.
// Ports:
//   clk, rst            : clock, synchronous active-low reset
//   m_ar*               : packed per-master AR requests (master 0 in low bits)
//   m_arready           : per-master ARREADY, only the granted bit can be high
//   m_rdata/rid/rresp/rlast : R payload broadcast to all masters
//   m_rvalid / m_rready : per-master R handshake, only the granted bit is live
//   ar* / arvalid / arready : slave-side AR channel
//   r* / rvalid / rready    : slave-side R channel
//   rid_err             : sticky, set when a beat's RID differs from granted ARID
// ---------------------------------------------------------------------------
module axi_rd_arbiter
  import axi_rd_pkg::*;
#(
  parameter int NUM_M  = 4,
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_M*ID_W-1:0]           m_arid,
  input  logic [NUM_M*ADDR_W-1:0]         m_araddr,
  input  logic [NUM_M*AXI_LEN_W-1:0]      m_arlen,
  input  logic [NUM_M*AXI_SIZE_W-1:0]     m_arsize,
  input  logic [NUM_M*AXI_BURST_W-1:0]    m_arburst,
  input  logic [NUM_M-1:0]                m_arvalid,
  output logic [NUM_M-1:0]                m_arready,
  output logic [DATA_W-1:0]               m_rdata,
  output logic [ID_W-1:0]                 m_rid,
  output logic [AXI_RESP_W-1:0]           m_rresp,
  output logic                            m_rlast,
  output logic [NUM_M-1:0]                m_rvalid,
  input  logic [NUM_M-1:0]                m_rready,
  output logic [ID_W-1:0]                 arid,
  output logic [ADDR_W-1:0]               araddr,
  output logic [AXI_LEN_W-1:0]            arlen,
  output logic [AXI_SIZE_W-1:0]           arsize,
  output logic [AXI_BURST_W-1:0]          arburst,
  output logic [AXI_LOCK_W-1:0]           arlock,
  output logic [AXI_CACHE_W-1:0]          arcache,
  output logic [AXI_PROT_W-1:0]           arprot,
  output logic                            arvalid,
  input  logic                            arready,
  input  logic [ID_W-1:0]                 rid,
  input  logic [DATA_W-1:0]               rdata,
  input  logic [AXI_RESP_W-1:0]           rresp,
  input  logic                            rlast,
  input  logic                            rvalid,
  output logic                            rready,
  output logic                            rid_err
);

  localparam int PTR_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_AR   = AR;
  localparam logic [1:0] ST_R    = R;

  logic [1:0]       r_state;
  logic [PTR_W-1:0] r_grant;
  logic [PTR_W-1:0] r_rr_ptr;
  logic [ID_W-1:0]  r_gnt_id;
  logic             r_rid_err;

  logic [PTR_W-1:0] w_pick;
  logic             w_any_req;
  logic [PTR_W-1:0] w_ptr_next;

  rr_arbiter #(
    .NUM_M (NUM_M),
    .PTR_W (PTR_W)
  ) u_rr (
    .i_req     (m_arvalid),
    .i_ptr     (r_rr_ptr),
    .o_grant   (w_pick),
    .o_any_req (w_any_req)
  );

  // The master just granted drops to lowest priority next round.
  assign w_ptr_next = (w_pick == PTR_W'(NUM_M-1)) ? '0 : w_pick + 1'b1;

  // AR fields always follow the registered grant; arvalid qualifies them.
  assign arid    = m_arid   [r_grant*ID_W        +: ID_W];
  assign araddr  = m_araddr [r_grant*ADDR_W      +: ADDR_W];
  assign arlen   = m_arlen  [r_grant*AXI_LEN_W   +: AXI_LEN_W];
  assign arsize  = m_arsize [r_grant*AXI_SIZE_W  +: AXI_SIZE_W];
  assign arburst = m_arburst[r_grant*AXI_BURST_W +: AXI_BURST_W];
  assign arlock  = ARLOCK_0;
  assign arcache = ARCACHE_0;
  assign arprot  = ARPROT_0;
  assign arvalid = (r_state == ST_AR) && m_arvalid[r_grant];

  // R payload is broadcast; only the handshake bits are steered.
  assign m_rdata = rdata;
  assign m_rid   = rid;
  assign m_rresp = rresp;
  assign m_rlast = rlast;
  assign rready  = (r_state == ST_R) && m_rready[r_grant];
  assign rid_err = r_rid_err;

  // Per-master handshake steering: only the granted master ever sees
  // ARREADY (in AR) or RVALID (in R); everyone else is held low.
  always_comb begin
    m_arready = '0;
    m_rvalid  = '0;
    if (r_state == ST_AR) begin
      m_arready[r_grant] = arready;
    end
    if (r_state == ST_R) begin
      m_rvalid[r_grant] = rvalid;
    end
  end

  // Grant FSM. Arbitration only happens in IDLE, which also gives the
  // one-cycle bubble between the last beat of one burst and the next AR.
  // The burst length is never counted; RLAST alone ends the R phase.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_grant   <= '0;
      r_rr_ptr  <= '0;
      r_gnt_id  <= '0;
      r_rid_err <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_grant  <= w_pick;
            r_gnt_id <= m_arid[w_pick*ID_W +: ID_W];
            r_rr_ptr <= w_ptr_next;
            r_state  <= ST_AR;
          end
        end
        ST_AR: begin
          if (arvalid && arready) begin
            r_state <= ST_R;
          end
        end
        ST_R: begin
          if (rvalid && rready && (rid != r_gnt_id)) begin
            r_rid_err <= 1'b1;
          end
          if (rvalid && rready && rlast) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
Shares one AXI read channel (AR + R) among NUM_M read masters, e.g. inst uncache, data uncache, icache refill and dcache refill. It grants one master at a time with round-robin priority, forwards that master's AR request, and steers the R beats back to it. Only one burst is outstanding at a time. It sits between the cache/uncache blocks and the top-level AXI read port.

Parameters:
NUM_M, 4, number of read masters (2..8); master 0 is index 0 of every packed vector
ID_W, 4, AXI ID width
ADDR_W, 32, address width
DATA_W, 32, read data width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
m_arid  in  NUM_M*ID_W  per-master ARID
m_araddr  in  NUM_M*ADDR_W  per-master ARADDR
m_arlen  in  NUM_M*4  per-master ARLEN
m_arsize  in  NUM_M*3  per-master ARSIZE
m_arburst  in  NUM_M*2  per-master ARBURST
m_arvalid  in  NUM_M  per-master ARVALID
m_arready  out  NUM_M  per-master ARREADY
m_rdata  out  DATA_W  RDATA, broadcast to all masters
m_rid  out  ID_W  RID, broadcast
m_rresp  out  2  RRESP, broadcast
m_rlast  out  1  RLAST, broadcast
m_rvalid  out  NUM_M  per-master RVALID, only the granted bit may be high
m_rready  in  NUM_M  per-master RREADY
arid/araddr/arlen/arsize/arburst  out  ID_W/ADDR_W/4/3/2  slave-side AR fields
arlock/arcache/arprot  out  2/4/3  tied to 0
arvalid  out  1  slave ARVALID
arready  in  1  slave ARREADY
rid/rdata/rresp/rlast/rvalid  in  ID_W/DATA_W/2/1/1  slave R channel
rready  out  1  slave RREADY
rid_err  out  1  sticky flag: an R beat arrived with rid != granted ARID

Behaviour:
- FSM with three states: IDLE, AR, R.
- Reset (rst=0 at a clk edge):
  - state=IDLE, grant=0, rr_ptr=0, rid_err=0.
  - arvalid=0, rready=0, all m_arready=0, all m_rvalid=0.
  - A reset mid-burst abandons the burst; the slave is reset on the same rst.
- IDLE:
  - If any m_arvalid is high, pick the first requester scanning rr_ptr, rr_ptr+1, ... modulo NUM_M (wraps at NUM_M-1 to 0).
  - Register grant, latch the granted m_arid into gnt_id, set rr_ptr=grant+1 mod NUM_M, go to AR.
  - With no requester, hold state.
- AR:
  - arvalid = m_arvalid[grant]; the AR fields are muxed combinationally from the granted master.
  - m_arready[grant] = arready; every other m_arready = 0.
  - When arvalid && arready, go to R.
  - Masters hold AR stable until the handshake (AXI rule); dropping m_arvalid is illegal and is not handled.
- R:
  - m_rvalid[grant] = rvalid; rready = m_rready[grant]. The data, id, resp and last fields are broadcast to all masters.
  - Every beat with rvalid && rready && rid != gnt_id sets rid_err. The beat is still forwarded.
  - When rvalid && rready && rlast, go to IDLE.
- Latency:
  - A request seen in IDLE at edge t gives arvalid=1 in cycle t+1.
  - After the last beat there is one mandatory IDLE bubble cycle before the next AR.
- Simultaneous events: new requests that arrive during AR or R are arbitrated only in the next IDLE. A request from the master that just finished competes normally; it has the lowest priority because rr_ptr has advanced past it.
- arlen is passed through unchanged; beats are counted only via rlast, with no internal beat counter.

Decomposition:
- Package axi_rd_pkg:
  - state enum {IDLE, AR, R}
  - AXI width constants
  - constants ARLOCK_0, ARCACHE_0, ARPROT_0
- One sub-module, rr_arbiter:
  - inputs: req[NUM_M], ptr
  - output: one-hot/index grant, plus any_req
  - purely combinational round-robin picker, reusable for the future write-channel arbiter.

Test Plan:
- Single master 0, arid=4, araddr=0x1FC0_0000, arlen=3; slave gives arready after 2 cycles and then 4 beats 0xA0..0xA3 -> araddr=0x1FC0_0000 on the slave, m_rvalid=4'b0001 on all 4 beats, FSM back in IDLE one cycle after rlast.
- Masters 0..3 all request with rr_ptr=0 and hold their requests -> grant order 0,1,2,3,0, with an IDLE bubble between bursts.
- Master 2 finishes its burst while master 2 and master 1 both request, rr_ptr=3 -> next grant is 1, because master 2 is lowest priority.
- Slave stalls: m_rready[grant]=0 for 3 cycles in mid-burst -> rready=0 and the slave beat is held, with no beat loss or duplication; rlast is delivered once.
- Slave returns rid=5 for a grant with arid=4 -> rid_err=1 from the next cycle, stays 1 until reset, and the burst still completes.
- rst=0 asserted in R state at beat 2 -> next cycle: IDLE, arvalid=0, rready=0, m_rvalid=0, rr_ptr=0.
